wb_debug_arbiter: RTL and testbench

Two-master, one-slave arbiter for the shared Wishbone-style memory bus. Master D is the UART debug command path (address/cs/we/wdata out, rdata/ack back); master C is the RISC core data port. The arbiter serialises their transactions onto the single slave port and routes the response to the granted master. Grants favour debug access without starving the core, and an optional watchdog prevents a dead slave from hanging the bus.

---
 rtl/wb_debug_arbiter.sv | 85 ++++++++
 tb/tb_wb_debug_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_debug_arbiter.sv
// wb_debug_arbiter: two-master (debug, core) to one-slave Wishbone arbiter; watchdog enabled by WB_DEBUG_ARBITER_TIMEOUT_EN
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module wb_debug_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [`ADDR_SIZE-1:0] Dbg_addr,
  input  logic                  Dbg_cs,
  input  logic                  Dbg_we,
  input  logic [`WORD_SIZE-1:0] Dbg_wdata,
  output logic [`WORD_SIZE-1:0] Dbg_rdata,
  output logic                  Dbg_ack,
  input  logic [`ADDR_SIZE-1:0] Core_addr,
  input  logic                  Core_cs,
  input  logic                  Core_we,
  input  logic [`WORD_SIZE-1:0] Core_wdata,
  output logic [`WORD_SIZE-1:0] Core_rdata,
  output logic                  Core_ack,
  input  logic                  Core_rst,
  output logic [`ADDR_SIZE-1:0] Wb_addr,
  output logic                  Wb_cs,
  output logic                  Wb_we,
  output logic [`WORD_SIZE-1:0] Wb_wdata,
  input  logic [`WORD_SIZE-1:0] Wb_rdata,
  input  logic                  Wb_ack,
  output logic                  Timeout_flag
);
  typedef enum logic [1:0] {IDLE, GNT_DBG, GNT_CORE} state_t;
  state_t state, state_nxt;
  logic last_dbg;
  logic core_req, gnt_dbg, gnt_core, sel_cs, fire, done;
  assign core_req = Core_cs & ~Core_rst;
  assign gnt_dbg  = state == GNT_DBG;
  assign gnt_core = state == GNT_CORE;
  assign sel_cs   = gnt_dbg ? Dbg_cs : gnt_core ? Core_cs : 1'b0;
  assign done     = sel_cs & (Wb_ack | fire);
`ifdef WB_DEBUG_ARBITER_TIMEOUT_EN
  logic [15:0] cnt;
  assign fire = sel_cs & ~Wb_ack & (cnt == 16'(TIMEOUT - 1));
  always_ff @(posedge Clk) begin
    if (!Rst || state == IDLE)
      cnt <= '0;
    else if (!Wb_ack)
      cnt <= cnt + 16'd1;
  end
  always_ff @(posedge Clk) begin
    if (!Rst)
      Timeout_flag <= 1'b0;
    else if (fire)
      Timeout_flag <= 1'b1;
  end
`else
  assign fire         = 1'b0;
  assign Timeout_flag = 1'b0;
`endif
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state    <= IDLE;
      last_dbg <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt != IDLE)
        last_dbg <= state_nxt == GNT_DBG;
    end
  end
  always_comb begin
    state_nxt = state == IDLE ? ((Dbg_cs && !(last_dbg && core_req)) ? GNT_DBG : core_req ? GNT_CORE : IDLE)
              : (!sel_cs || done) ? IDLE : state;
  end
  assign Wb_cs      = sel_cs;
  assign Wb_addr    = gnt_dbg ? Dbg_addr : gnt_core ? Core_addr : '0;
  assign Wb_we      = gnt_dbg ? Dbg_we : gnt_core ? Core_we : 1'b0;
  assign Wb_wdata   = gnt_dbg ? Dbg_wdata : gnt_core ? Core_wdata : '0;
  assign Dbg_ack    = gnt_dbg & done;
  assign Core_ack   = gnt_core & done;
  assign Dbg_rdata  = fire ? '1 : Wb_rdata;
  assign Core_rdata = fire ? '1 : Wb_rdata;
endmodule

// File: tb/tb_wb_debug_arbiter.sv
// tb_wb_debug_arbiter: table, directed and randomized checks of the debug/core Wishbone arbiter
`timescale 1ns/1ps
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_wb_debug_arbiter;
  localparam int AW = `ADDR_SIZE;
  localparam int WW = `WORD_SIZE;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] Dbg_addr, Core_addr, Wb_addr;
  logic [WW-1:0] Dbg_wdata, Core_wdata, Wb_wdata, Dbg_rdata, Core_rdata, Wb_rdata;
  logic Dbg_cs, Dbg_we, Dbg_ack, Core_cs, Core_we, Core_ack, Core_rst;
  logic Wb_cs, Wb_we, Wb_ack, Timeout_flag;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_debug_arbiter #(.TIMEOUT(TO)) dut (
    .Clk(clk), .Rst(rst_n),
    .Dbg_addr(Dbg_addr), .Dbg_cs(Dbg_cs), .Dbg_we(Dbg_we), .Dbg_wdata(Dbg_wdata),
    .Dbg_rdata(Dbg_rdata), .Dbg_ack(Dbg_ack),
    .Core_addr(Core_addr), .Core_cs(Core_cs), .Core_we(Core_we), .Core_wdata(Core_wdata),
    .Core_rdata(Core_rdata), .Core_ack(Core_ack), .Core_rst(Core_rst),
    .Wb_addr(Wb_addr), .Wb_cs(Wb_cs), .Wb_we(Wb_we), .Wb_wdata(Wb_wdata),
    .Wb_rdata(Wb_rdata), .Wb_ack(Wb_ack), .Timeout_flag(Timeout_flag)
  );

  typedef struct {
    logic d, c, r, a;
    logic [31:0] eaddr;
    logic ecs, edk, eck;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] f, input logic [31:0] ea);
    vec_t v;
    v.d = f[6]; v.c = f[5]; v.r = f[4]; v.a = f[3];
    v.ecs = f[2]; v.edk = f[1]; v.eck = f[0];
    v.eaddr = ea;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic d, input logic c, input logic r, input logic a);
    Dbg_cs = d; Core_cs = c; Core_rst = r; Wb_ack = a;
  endtask

  task automatic fixed_masters();
    Dbg_addr = AW'(32'h10); Dbg_we = 1'b0; Dbg_wdata = WW'(32'hA5A50001);
    Core_addr = AW'(32'h40); Core_we = 1'b1; Core_wdata = WW'(32'h12345678);
    Wb_rdata = WW'(32'hCAFEF00D);
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1, 1, 0, 1);
    @(negedge clk);
    #1;
    if (chk) begin
      check("rst_wb_cs", Wb_cs, 0);
      check("rst_dbg_ack", Dbg_ack, 0);
      check("rst_core_ack", Core_ack, 0);
      check("rst_wb_addr", Wb_addr, 0);
      check("rst_flag", Timeout_flag, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
  endtask

  vec_t tbl[28];

  initial begin
    fixed_masters();
    drive(0, 0, 0, 0);
    tbl[0]  = mk(7'b1000_000, 32'h00);
    tbl[1]  = mk(7'b1000_100, 32'h10);
    tbl[2]  = mk(7'b1000_100, 32'h10);
    tbl[3]  = mk(7'b1001_110, 32'h10);
    tbl[4]  = mk(7'b0000_000, 32'h00);
    tbl[5]  = mk(7'b1100_000, 32'h00);
    tbl[6]  = mk(7'b1101_101, 32'h40);
    tbl[7]  = mk(7'b1100_000, 32'h00);
    tbl[8]  = mk(7'b1101_110, 32'h10);
    tbl[9]  = mk(7'b1100_000, 32'h00);
    tbl[10] = mk(7'b1101_101, 32'h40);
    tbl[11] = mk(7'b1100_000, 32'h00);
    tbl[12] = mk(7'b1101_110, 32'h10);
    tbl[13] = mk(7'b0100_000, 32'h00);
    tbl[14] = mk(7'b0101_101, 32'h40);
    tbl[15] = mk(7'b0110_000, 32'h00);
    tbl[16] = mk(7'b0111_000, 32'h00);
    tbl[17] = mk(7'b0110_000, 32'h00);
    tbl[18] = mk(7'b0100_000, 32'h00);
    tbl[19] = mk(7'b0100_100, 32'h40);
    tbl[20] = mk(7'b0110_100, 32'h40);
    tbl[21] = mk(7'b0111_101, 32'h40);
    tbl[22] = mk(7'b0110_000, 32'h00);
    tbl[23] = mk(7'b0110_000, 32'h00);
    tbl[24] = mk(7'b1110_000, 32'h00);
    tbl[25] = mk(7'b1110_100, 32'h10);
    tbl[26] = mk(7'b0110_000, 32'h10);
    tbl[27] = mk(7'b0000_000, 32'h00);

    do_reset(1);

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      drive(tbl[i].d, tbl[i].c, tbl[i].r, tbl[i].a);
      #1;
      check($sformatf("tbl%0d_cs", i), Wb_cs, tbl[i].ecs);
      check($sformatf("tbl%0d_addr", i), Wb_addr, tbl[i].eaddr);
      check($sformatf("tbl%0d_we", i), Wb_we, tbl[i].eaddr == 32'h40);
      check($sformatf("tbl%0d_wdata", i), Wb_wdata,
            tbl[i].eaddr == 32'h40 ? 32'h12345678 : tbl[i].eaddr == 32'h10 ? 32'hA5A50001 : 32'h0);
      check($sformatf("tbl%0d_dack", i), Dbg_ack, tbl[i].edk);
      check($sformatf("tbl%0d_cack", i), Core_ack, tbl[i].eck);
      if (tbl[i].edk) check($sformatf("tbl%0d_drdata", i), Dbg_rdata, 32'hCAFEF00D);
      if (tbl[i].eck) check($sformatf("tbl%0d_crdata", i), Core_rdata, 32'hCAFEF00D);
    end
    check("tbl_flag", Timeout_flag, 0);

    do_reset(0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(0, 1, 1, 0);
      #1;
      check("crst_mask_cs", Wb_cs, 0);
    end
    @(negedge clk);
    drive(0, 1, 0, 0);
    #1;
    check("crst_release_idle", Wb_cs, 0);
    @(negedge clk);
    #1;
    check("crst_release_cs", Wb_cs, 1);
    check("crst_release_addr", Wb_addr, 32'h40);
    @(negedge clk);
    drive(0, 1, 0, 1);
    #1;
    check("crst_release_ack", Core_ack, 1);

    do_reset(0);
    @(negedge clk);
    drive(1, 0, 0, 0);
    @(negedge clk);
    #1;
    check("rstg_cs", Wb_cs, 1);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstg_drop_cs", Wb_cs, 0);
    check("rstg_drop_dack", Dbg_ack, 0);
    @(negedge clk);
    drive(1, 1, 0, 1);
    #1;
    check("rstg_dbg_first_addr", Wb_addr, 32'h10);
    check("rstg_dbg_first_ack", Dbg_ack, 1);
    check("rstg_core_noack", Core_ack, 0);

`ifdef WB_DEBUG_ARBITER_TIMEOUT_EN
    do_reset(0);
    @(negedge clk);
    drive(1, 0, 0, 0);
    for (int g = 1; g <= TO; g++) begin
      @(negedge clk);
      #1;
      check("to_cs", Wb_cs, 1);
      check("to_dack", Dbg_ack, g == TO);
      check("to_flag_pre", Timeout_flag, 0);
      if (g == TO) check("to_rdata", Dbg_rdata, 32'hFFFFFFFF);
    end
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    check("to_idle", Wb_cs, 0);
    check("to_flag", Timeout_flag, 1);
    repeat (5) @(negedge clk);
    #1;
    check("to_flag_sticky", Timeout_flag, 1);
    do_reset(0);
    #1;
    check("to_flag_cleared", Timeout_flag, 0);
    @(negedge clk);
    drive(1, 0, 0, 0);
    for (int g = 1; g <= TO; g++) begin
      @(negedge clk);
      drive(1, 0, 0, g == TO);
      #1;
      check("tob_dack", Dbg_ack, g == TO);
      if (g == TO) check("tob_rdata", Dbg_rdata, 32'hCAFEF00D);
    end
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    check("tob_noflag", Timeout_flag, 0);
`endif

    do_reset(0);
    begin
      int owner = 0;
      int last = 2;
      int waited = 0;
      bit flag_m = 0;
      bit dp = 0;
      bit cp = 0;
      Core_rst = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
        bit cs_e, to_e, ack_e, creq;
        logic [AW-1:0] addr_e;
        logic [WW-1:0] wdata_e;
        logic we_e;
        @(negedge clk);
        if (!dp && $urandom_range(2) == 0) begin
          dp = 1; Dbg_addr = AW'($urandom); Dbg_we = 1'($urandom_range(1)); Dbg_wdata = WW'($urandom);
        end
        if (!cp && $urandom_range(2) == 0) begin
          cp = 1; Core_addr = AW'($urandom); Core_we = 1'($urandom_range(1)); Core_wdata = WW'($urandom);
        end
        if ($urandom_range(7) == 0) Core_rst = ~Core_rst;
        Dbg_cs = dp;
        Core_cs = cp;
        Wb_ack = $urandom_range(3) == 0;
        Wb_rdata = WW'($urandom);
        #1;
        cs_e = owner == 1 ? Dbg_cs : owner == 2 ? Core_cs : 1'b0;
        to_e = 0;
`ifdef WB_DEBUG_ARBITER_TIMEOUT_EN
        to_e = cs_e && !Wb_ack && waited == TO - 1;
`endif
        ack_e = cs_e && (Wb_ack || to_e);
        addr_e = owner == 1 ? Dbg_addr : owner == 2 ? Core_addr : '0;
        we_e = owner == 1 ? Dbg_we : owner == 2 ? Core_we : 1'b0;
        wdata_e = owner == 1 ? Dbg_wdata : owner == 2 ? Core_wdata : '0;
        check("rnd_cs", Wb_cs, cs_e);
        check("rnd_addr", Wb_addr, addr_e);
        check("rnd_we", Wb_we, we_e);
        check("rnd_wdata", Wb_wdata, wdata_e);
        check("rnd_dack", Dbg_ack, ack_e && owner == 1);
        check("rnd_cack", Core_ack, ack_e && owner == 2);
        check("rnd_drdata", Dbg_rdata, to_e ? {WW{1'b1}} : Wb_rdata);
        check("rnd_crdata", Core_rdata, to_e ? {WW{1'b1}} : Wb_rdata);
        check("rnd_flag", Timeout_flag, flag_m);
        flag_m = flag_m | to_e;
        if (ack_e && owner == 1) dp = 0;
        if (ack_e && owner == 2) cp = 0;
        if (owner == 0) begin
          creq = Core_cs && !Core_rst;
          if (Dbg_cs && !(last == 1 && creq)) begin owner = 1; last = 1; waited = 0; end
          else if (creq) begin owner = 2; last = 2; waited = 0; end
        end else if (!cs_e || ack_e) begin
          owner = 0;
        end else begin
          waited++;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
